burst_grant_sched: RTL and testbench

Burst-level scheduler that shares the pixel datapath (arbiter → output FIFO → master 0) between two slave requesters. It grants one requester at a time for a whole burst of 1–16 32-bit words and throttles beats against `fifo_full`. For processing-mode bursts it waits for `mstr0_cmplt` before re-arbitrating. Placement: in front of the arbiter mux; its `grant` drives the arbiter's slave select.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 20 ++
 rtl/burst_grant_sched.sv | 140 ++++++++++++++
 tb/tb_burst_grant_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the burst grant scheduler.
package arb_pkg;

    typedef enum logic [1:0] {
        MODE_BYP  = 2'b00,
        MODE_RSVD = 2'b01,
        MODE_PROC = 2'b10,
        MODE_PRIO = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_XFER    = 2'b01,
        ST_WAIT    = 2'b10
    } state_e;

    localparam int LEN_W_DFLT   = 4;
    localparam int TIMEOUT_DFLT = 200;

endpackage

// File: rtl/rr_pick2.sv
// Two-way picker: priority requesters first, round-robin to break ties.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic [1:0] prio,
    input  logic       last,
    output logic [1:0] gnt
);

    logic [1:0] cand;

    always_comb begin
        cand = ((req & prio) != 2'b00) ? (req & prio) : req;
        gnt  = cand;
        // last holds the index granted most recently; the other one wins a tie
        if (cand == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/burst_grant_sched.sv
// Burst-level scheduler sharing the pixel datapath between two requesters.
module burst_grant_sched
    import arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int LEN_W   = LEN_W_DFLT,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = TIMEOUT_DFLT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0][1:0]       req_mode,
    input  logic [NREQ-1:0][LEN_W-1:0] req_len,
    input  logic [NREQ-1:0]            beat_vld,
    input  logic                       fifo_full,
    input  logic                       mstr0_cmplt,
    output logic [NREQ-1:0]            grant,
    output logic [1:0]                 grant_mode,
    output logic                       beat_acc,
    output logic [LEN_W-1:0]           beat_idx,
    output logic                       burst_done,
    output logic                       timeout_err,
    output logic                       busy
);

    state_e            state, state_nxt;
    logic [NREQ-1:0]   grant_nxt;
    logic [1:0]        grant_mode_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt, beat_idx_nxt;
    logic              g_idx, g_idx_nxt;
    logic              last_q, last_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic              done_nxt, terr_nxt;
    logic [NREQ-1:0]   prio, pick;

    always_comb begin
        prio = '0;
        for (int i = 0; i < NREQ; i++) begin
            prio[i] = (req_mode[i] == MODE_PRIO);
        end
    end

    rr_pick2 u_pick (
        .req  (req),
        .prio (prio),
        .last (last_q),
        .gnt  (pick)
    );

    assign beat_acc = (state == ST_XFER) && beat_vld[g_idx] && !fifo_full;

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        grant_mode_nxt = grant_mode;
        len_nxt        = len_q;
        beat_idx_nxt   = beat_idx;
        g_idx_nxt      = g_idx;
        last_nxt       = last_q;
        to_cnt_nxt     = to_cnt;
        done_nxt       = 1'b0;
        terr_nxt       = 1'b0;
        case (state)
            ST_IDLE: begin
                beat_idx_nxt = '0;
                if (|req) begin
                    g_idx_nxt      = pick[1];
                    grant_nxt      = pick;
                    grant_mode_nxt = req_mode[pick[1]];
                    len_nxt        = req_len[pick[1]];
                    state_nxt      = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat_acc) begin
                    if (beat_idx == len_q) begin
                        if (grant_mode == MODE_PROC) begin
                            state_nxt  = ST_WAIT;
                            to_cnt_nxt = '0;
                        end else begin
                            state_nxt = ST_IDLE;
                            grant_nxt = '0;
                            done_nxt  = 1'b1;
                            last_nxt  = g_idx;
                        end
                    end else begin
                        beat_idx_nxt = beat_idx + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // completion takes precedence over a coincident timeout
                if (mstr0_cmplt) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    done_nxt  = 1'b1;
                    last_nxt  = g_idx;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    terr_nxt  = 1'b1;
                    last_nxt  = g_idx;
                end else if (to_cnt != '1) begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_mode  <= '0;
            len_q       <= '0;
            beat_idx    <= '0;
            g_idx       <= 1'b0;
            last_q      <= 1'b1;
            to_cnt      <= '0;
            burst_done  <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_mode  <= grant_mode_nxt;
            len_q       <= len_nxt;
            beat_idx    <= beat_idx_nxt;
            g_idx       <= g_idx_nxt;
            last_q      <= last_nxt;
            to_cnt      <= to_cnt_nxt;
            burst_done  <= done_nxt;
            timeout_err <= terr_nxt;
            busy        <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_burst_grant_sched.sv
// Directed self-checking bench for burst_grant_sched.
module tb_burst_grant_sched;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req;
    logic [1:0][1:0] req_mode;
    logic [1:0][3:0] req_len;
    logic [1:0]      beat_vld;
    logic            fifo_full;
    logic            mstr0_cmplt;
    logic [1:0]      grant;
    logic [1:0]      grant_mode;
    logic            beat_acc;
    logic [3:0]      beat_idx;
    logic            burst_done;
    logic            timeout_err;
    logic            busy;

    int tests  = 0;
    int failed = 0;

    burst_grant_sched #(
        .NREQ    (2),
        .LEN_W   (4),
        .TO_W    (8),
        .TIMEOUT (200)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_mode    (req_mode),
        .req_len     (req_len),
        .beat_vld    (beat_vld),
        .fifo_full   (fifo_full),
        .mstr0_cmplt (mstr0_cmplt),
        .grant       (grant),
        .grant_mode  (grant_mode),
        .beat_acc    (beat_acc),
        .beat_idx    (beat_idx),
        .burst_done  (burst_done),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int done_at;
        int k;
        logic [1:0] exp_g [3];
        logic [1:0] m0 [3];
        logic [1:0] m1 [3];

        rst_n = 1'b0; req = '0; req_mode = '0; req_len = '0;
        beat_vld = '0; fifo_full = 1'b0; mstr0_cmplt = 1'b0;

        // Reset state
        tick(); tick();
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_grant_mode", grant_mode, 2'b00);
        chk("rst_beat_idx", beat_idx, 4'd0);
        chk("rst_done", burst_done, 1'b0);
        chk("rst_terr", timeout_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_acc", beat_acc, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single bypass burst, len 3
        req = 2'b01; req_mode[0] = 2'b00; req_len[0] = 4'd3; beat_vld = 2'b01;
        tick();
        req = 2'b00;
        chk("byp_busy", busy, 1'b1);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("byp_grant", grant, 2'b01);
            chk("byp_idx", beat_idx, i);
            chk("byp_done_early", burst_done, 1'b0);
            if (beat_acc) acc++;
            tick();
        end
        chk("byp_accepts", acc, 4);
        beat_vld = 2'b00;
        #1;
        chk("byp_done", burst_done, 1'b1);
        chk("byp_grant_drop", grant, 2'b00);
        chk("byp_busy_drop", busy, 1'b0);
        chk("byp_acc_idle", beat_acc, 1'b0);
        tick();
        chk("byp_done_pulse", burst_done, 1'b0);

        // Contention from reset: RR 01, 10, 01
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 2'b11; req_mode = '0; req_len = '0; beat_vld = 2'b11;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_grant", grant, exp_g[i]);
            tick();
            chk("rr_done", burst_done, 1'b1);
            chk("rr_gap", grant, 2'b00);
        end
        req = 2'b00;
        tick();

        // Priority: pointer currently favours req1
        m0[0] = 2'b11; m1[0] = 2'b00; exp_g[0] = 2'b01;
        m0[1] = 2'b11; m1[1] = 2'b11; exp_g[1] = 2'b10;
        m0[2] = 2'b00; m1[2] = 2'b11; exp_g[2] = 2'b10;
        req = 2'b11;
        req_mode[0] = m0[0]; req_mode[1] = m1[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("prio_grant", grant, exp_g[i]);
            chk("prio_mode", grant_mode, exp_g[i][0] ? m0[i] : m1[i]);
            tick();
            chk("prio_done", burst_done, 1'b1);
            if (i < 2) begin
                req_mode[0] = m0[i+1]; req_mode[1] = m1[i+1];
            end
        end
        req = 2'b00; req_mode = '0;
        tick();

        // Backpressure: fifo_full for 2 cycles mid-burst
        req = 2'b01; req_len[0] = 4'd3; beat_vld = 2'b01;
        tick();
        req = 2'b00;
        acc = 0; done_at = -1;
        for (int i = 0; i < 8; i++) begin
            fifo_full = (i == 2 || i == 3);
            #1;
            if (beat_acc) acc++;
            if (burst_done && done_at < 0) done_at = i;
            if (i == 3) chk("bp_idx_stall", beat_idx, 4'd2);
            tick();
        end
        fifo_full = 1'b0; beat_vld = 2'b00;
        chk("bp_accepts", acc, 4);
        chk("bp_done_cycle", done_at, 6);

        // Processed burst, early completion ignored, other requester's beats ignored
        req = 2'b01; req_mode[0] = 2'b10; req_len[0] = 4'd0;
        tick();
        req = 2'b00;
        chk("proc_mode", grant_mode, 2'b10);
        mstr0_cmplt = 1'b1; beat_vld = 2'b10;
        #1;
        chk("proc_foreign_vld", beat_acc, 1'b0);
        tick();
        mstr0_cmplt = 1'b0; beat_vld = 2'b01;
        chk("proc_early_cmplt", burst_done, 1'b0);
        chk("proc_still_busy", busy, 1'b1);
        #1;
        chk("proc_acc", beat_acc, 1'b1);
        tick();
        beat_vld = 2'b00;
        for (int i = 0; i < 5; i++) begin
            chk("proc_wait_grant", grant, 2'b01);
            chk("proc_wait_nodone", burst_done, 1'b0);
            tick();
        end
        mstr0_cmplt = 1'b1;
        tick();
        mstr0_cmplt = 1'b0;
        chk("proc_done", burst_done, 1'b1);
        chk("proc_no_terr", timeout_err, 1'b0);
        chk("proc_grant_drop", grant, 2'b00);

        // Timeout with no completion
        req = 2'b01; beat_vld = 2'b01;
        tick();
        req = 2'b00;
        tick();
        beat_vld = 2'b00;
        k = 0; acc = 0;
        while (!timeout_err && k < 300) begin
            if (burst_done) acc++;
            tick();
            k++;
        end
        chk("to_cycles", k, 200);
        chk("to_no_done_wait", acc, 0);
        chk("to_done_low", burst_done, 1'b0);
        chk("to_busy", busy, 1'b0);
        chk("to_grant", grant, 2'b00);
        req = 2'b10; req_mode[1] = 2'b00; req_len[1] = 4'd0; beat_vld = 2'b10;
        tick();
        req = 2'b00;
        chk("to_pulse", timeout_err, 1'b0);
        chk("to_next_grant", grant, 2'b10);
        tick();
        beat_vld = 2'b00;
        chk("to_next_done", burst_done, 1'b1);

        // Completion on the timeout cycle
        req = 2'b01; beat_vld = 2'b01;
        tick();
        req = 2'b00;
        tick();
        beat_vld = 2'b00;
        for (int i = 0; i < 199; i++) tick();
        chk("race_pre_terr", timeout_err, 1'b0);
        mstr0_cmplt = 1'b1;
        tick();
        mstr0_cmplt = 1'b0;
        chk("race_done", burst_done, 1'b1);
        chk("race_terr", timeout_err, 1'b0);
        req_mode = '0;

        // Reset mid-burst, then simultaneous requests from reset
        req = 2'b11; req_len[0] = 4'd3; req_len[1] = 4'd3; beat_vld = 2'b11;
        tick();
        req = 2'b00;
        chk("mid_busy", busy, 1'b1);
        tick(); tick();
        chk("mid_idx", beat_idx, 4'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_grant", grant, 2'b00);
        chk("mid_busy0", busy, 1'b0);
        chk("mid_idx0", beat_idx, 4'd0);
        chk("mid_done0", burst_done, 1'b0);
        chk("mid_mode0", grant_mode, 2'b00);
        chk("mid_terr0", timeout_err, 1'b0);
        req = 2'b11;
        tick();
        req = 2'b00;
        chk("post_rst_grant", grant, 2'b01);
        tick(); tick(); tick(); tick();
        chk("post_rst_done", burst_done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
